// File: rtl/hamming_dist_seq_pkg.sv
// Shared types and sizing helpers for the sequential Hamming-distance engine.
package ham_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } ham_state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CHUNK = 4;

    // Enough bits to hold a distance of exactly WIDTH.
    function automatic int res_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage

// File: rtl/hamming_dist_seq_if.sv
// Request/response bundle between the execute stage and the Hamming-distance engine.
interface hamming_dist_seq_if
    import ham_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic                          start;
    logic [WIDTH-1:0]              src1;
    logic [WIDTH-1:0]              src2;
    logic                          busy;
    logic                          done;
    logic [res_width(WIDTH)-1:0]   ham_out;

    modport master (
        output start, src1, src2,
        input  busy, done, ham_out
    );

    modport slave (
        input  start, src1, src2,
        output busy, done, ham_out
    );

endinterface

// File: rtl/hamming_dist_seq_chunk_popcount.sv
// Combinational population count of one CHUNK-bit slice, built as a ripple of small adds.
module chunk_popcount #(
    parameter int CHUNK = 4,
    parameter int CW    = $clog2(CHUNK) + 1
) (
    input  logic [CHUNK-1:0] bits,
    output logic [CW-1:0]    count
);

    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_sum
        logic [CW-1:0] s;
        if (gi == 0) begin : g_first
            assign s = CW'(bits[0]);
        end else begin : g_rest
            assign s = g_sum[gi-1].s + CW'(bits[gi]);
        end
    end

    assign count = g_sum[CHUNK-1].s;

endmodule

// File: rtl/hamming_dist_seq.sv
// Multi-cycle Hamming distance: shifts src1^src2 right CHUNK bits per cycle and accumulates
// each slice's popcount; optionally stops once the remaining difference bits are all zero.
module hamming_dist_seq
    import ham_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CHUNK      = DEF_CHUNK,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    hamming_dist_seq_if.slave  bus
);

    localparam int N        = WIDTH / CHUNK;
    localparam int RW       = res_width(WIDTH);
    localparam int CW       = $clog2(CHUNK) + 1;
    localparam int IDXW     = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

    ham_state_e        state_reg, state_next;
    logic [WIDTH-1:0]  diff_reg,  diff_next;
    logic [RW-1:0]     acc_reg,   acc_next;
    logic [RW-1:0]     ham_reg,   ham_next;
    logic [IDXW-1:0]   idx_reg,   idx_next;

    logic [CW-1:0]     chunk_cnt;
    logic [RW-1:0]     sum;

    chunk_popcount #(.CHUNK(CHUNK), .CW(CW)) u_popcount (
        .bits  (diff_reg[CHUNK-1:0]),
        .count (chunk_cnt)
    );

    assign sum = acc_reg + RW'(chunk_cnt);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            diff_reg  <= '0;
            acc_reg   <= '0;
            ham_reg   <= '0;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            diff_reg  <= diff_next;
            acc_reg   <= acc_next;
            ham_reg   <= ham_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        diff_next  = diff_reg;
        acc_next   = acc_reg;
        ham_next   = ham_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = COUNT;
                    diff_next  = bus.src1 ^ bus.src2;
                    acc_next   = '0;
                    idx_next   = '0;
                end else if (state_reg == DONE) begin
                    state_next = IDLE;
                end
            end
            COUNT: begin
                // The zero-remainder exit wins over the chunk counter.
                if (EARLY_EXIT && (diff_reg == '0)) begin
                    state_next = DONE;
                    ham_next   = acc_reg;
                end else begin
                    acc_next  = sum;
                    diff_next = diff_reg >> CHUNK;
                    if (idx_reg == IDX_LAST) begin
                        state_next = DONE;
                        ham_next   = sum;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy    = (state_reg == COUNT);
    assign bus.done    = (state_reg == DONE);
    assign bus.ham_out = ham_reg;

endmodule

// File: tb/tb_hamming_dist_seq.sv
// Directed and randomised checks of hamming_dist_seq with and without early exit.
module tb_hamming_dist_seq;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    hamming_dist_seq_if #(.WIDTH(32)) i0 ();
    hamming_dist_seq_if #(.WIDTH(32)) i1 ();

    hamming_dist_seq #(.WIDTH(32), .CHUNK(4), .EARLY_EXIT(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (i0)
    );

    hamming_dist_seq #(.WIDTH(32), .CHUNK(4), .EARLY_EXIT(1'b1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (i1)
    );

    function automatic int ref_pop(input logic [31:0] x);
        int c = 0;
        for (int i = 0; i < 32; i++) c += int'(x[i]);
        return c;
    endfunction

    // Exit edge index after the accepting edge.
    function automatic int ref_lat(input bit ee, input logic [31:0] x);
        int k = 0;
        if (!ee) return 8;
        for (int c = 7; c >= 0; c--) begin
            if (x[c*4 +: 4] != 4'h0) begin
                k = c + 1;
                break;
            end
        end
        return (k + 1 > 8) ? 8 : k + 1;
    endfunction

    task automatic drive(input bit sel, input logic st, input logic [31:0] a, input logic [31:0] b);
        if (sel) begin
            i1.start = st; i1.src1 = a; i1.src2 = b;
        end else begin
            i0.start = st; i0.src1 = a; i0.src2 = b;
        end
    endtask

    // Issues one request and measures edges from acceptance to done; lat = -1 on timeout.
    task automatic run_req(input bit sel, input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic [5:0] res, output int busy_bad);
        logic d, bz;
        @(negedge clk);
        drive(sel, 1'b1, a, b);
        @(posedge clk); #1;
        drive(sel, 1'b0, ~a, ~b);
        busy_bad = ((sel ? i1.busy : i0.busy) !== 1'b1) ? 1 : 0;
        lat = -1;
        res = 'x;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            d  = sel ? i1.done : i0.done;
            bz = sel ? i1.busy : i0.busy;
            if (d === 1'b1) begin
                if (bz !== 1'b0) busy_bad++;
                lat = c;
                res = sel ? i1.ham_out : i0.ham_out;
                break;
            end else if (bz !== 1'b1) begin
                busy_bad++;
            end
        end
    endtask

    task automatic test_reset();
        int lat, bb;
        logic [5:0] res;
        drive(1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, '0, '0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (i0.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy0 got=%b exp=0", i0.busy); end
        n_cmp++; if (i0.done !== 1'b0) begin n_err++; $display("FAIL reset_done0 got=%b exp=0", i0.done); end
        n_cmp++; if (i0.ham_out !== 6'd0) begin n_err++; $display("FAIL reset_ham0 got=%0d exp=0", i0.ham_out); end
        n_cmp++; if (i1.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy1 got=%b exp=0", i1.busy); end
        n_cmp++; if (i1.done !== 1'b0) begin n_err++; $display("FAIL reset_done1 got=%b exp=0", i1.done); end
        n_cmp++; if (i1.ham_out !== 6'd0) begin n_err++; $display("FAIL reset_ham1 got=%0d exp=0", i1.ham_out); end
        @(negedge clk);
        rst = 1'b0;
        run_req(1'b0, 32'hFFFF_FFFF, 32'h0, lat, res, bb);
        $display("full_run ee=0: lat=%0d ham=%0d", lat, res);
        n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL full_lat got=%0d exp=8", lat); end
        n_cmp++; if (res !== 6'd32) begin n_err++; $display("FAIL full_ham got=%0d exp=32", res); end
        n_cmp++; if (bb !== 0) begin n_err++; $display("FAIL full_busy got=%0d bad cycles exp=0", bb); end
    endtask

    task automatic test_equal();
        int lat, bb;
        logic [5:0] res;
        run_req(1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, lat, res, bb);
        $display("equal ee=1: lat=%0d ham=%0d", lat, res);
        n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL equal_lat got=%0d exp=1", lat); end
        n_cmp++; if (res !== 6'd0) begin n_err++; $display("FAIL equal_ham got=%0d exp=0", res); end
        n_cmp++; if (bb !== 0) begin n_err++; $display("FAIL equal_busy got=%0d exp=0", bb); end
    endtask

    task automatic test_early_low();
        int lat, bb;
        logic [5:0] res;
        run_req(1'b1, 32'h0000_000F, 32'h0000_0001, lat, res, bb);
        $display("early_low ee=1: lat=%0d ham=%0d", lat, res);
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL early_lat got=%0d exp=2", lat); end
        n_cmp++; if (res !== 6'd3) begin n_err++; $display("FAIL early_ham got=%0d exp=3", res); end
        n_cmp++; if (bb !== 0) begin n_err++; $display("FAIL early_busy got=%0d exp=0", bb); end
    endtask

    task automatic test_back_to_back();
        // ham_out still holds 3 from the previous request on this instance.
        @(negedge clk);
        drive(1'b1, 1'b1, 32'hA5A5_A5A5, 32'h5A5A_5A5A);
        @(posedge clk); #1;
        n_cmp++; if (i1.busy !== 1'b1) begin n_err++; $display("FAIL b2b_e0_busy got=%b exp=1", i1.busy); end
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            drive(1'b1, (c < 7) ? c[0] : 1'b0, $urandom, $urandom);
            @(posedge clk); #1;
            if (c < 8) begin
                n_cmp++;
                if (i1.busy !== 1'b1 || i1.done !== 1'b0 || i1.ham_out !== 6'd3) begin
                    n_err++;
                    $display("FAIL b2b_busy_e%0d got busy=%b done=%b ham=%0d exp 1/0/3", c, i1.busy, i1.done, i1.ham_out);
                end
            end else begin
                n_cmp++;
                if (i1.busy !== 1'b0 || i1.done !== 1'b1 || i1.ham_out !== 6'd32) begin
                    n_err++;
                    $display("FAIL b2b_first_done got busy=%b done=%b ham=%0d exp 0/1/32", i1.busy, i1.done, i1.ham_out);
                end
            end
        end
        $display("b2b first: ham=%0d", i1.ham_out);
        @(negedge clk);
        drive(1'b1, 1'b1, 32'h1, 32'h0);
        @(posedge clk); #1;
        drive(1'b1, 1'b0, 32'h0, 32'h0);
        n_cmp++;
        if (i1.busy !== 1'b1 || i1.done !== 1'b0 || i1.ham_out !== 6'd32) begin
            n_err++;
            $display("FAIL b2b_restart got busy=%b done=%b ham=%0d exp 1/0/32", i1.busy, i1.done, i1.ham_out);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (i1.busy !== 1'b1 || i1.done !== 1'b0 || i1.ham_out !== 6'd32) begin
            n_err++;
            $display("FAIL b2b_hold got busy=%b done=%b ham=%0d exp 1/0/32", i1.busy, i1.done, i1.ham_out);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (i1.busy !== 1'b0 || i1.done !== 1'b1 || i1.ham_out !== 6'd1) begin
            n_err++;
            $display("FAIL b2b_second_done got busy=%b done=%b ham=%0d exp 0/1/1", i1.busy, i1.done, i1.ham_out);
        end
        $display("b2b second: ham=%0d", i1.ham_out);
    endtask

    task automatic test_reset_mid();
        int lat, bb;
        logic [5:0] res;
        @(negedge clk);
        drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'h0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (i0.busy !== 1'b0 || i0.done !== 1'b0 || i0.ham_out !== 6'd0) begin
            n_err++;
            $display("FAIL midrst_dut0 got busy=%b done=%b ham=%0d exp 0/0/0", i0.busy, i0.done, i0.ham_out);
        end
        n_cmp++;
        if (i1.ham_out !== 6'd0) begin
            n_err++;
            $display("FAIL midrst_dut1_ham got=%0d exp=0", i1.ham_out);
        end
        $display("mid_reset: busy=%b ham=%0d", i0.busy, i0.ham_out);
        @(negedge clk);
        rst = 1'b0;
        run_req(1'b0, 32'h0000_00FF, 32'h0, lat, res, bb);
        $display("after_reset ee=0: lat=%0d ham=%0d", lat, res);
        n_cmp++; if (lat !== 8) begin n_err++; $display("FAIL postrst_lat got=%0d exp=8", lat); end
        n_cmp++; if (res !== 6'd8) begin n_err++; $display("FAIL postrst_ham got=%0d exp=8", res); end
        n_cmp++; if (bb !== 0) begin n_err++; $display("FAIL postrst_busy got=%0d exp=0", bb); end
    endtask

    task automatic test_random();
        int lat, bb, exp_lat;
        logic [5:0] res;
        logic [31:0] a, b, m;
        for (int t = 0; t < 1000; t++) begin
            a = $urandom;
            m = 32'hFFFF_FFFF >> $urandom_range(0, 32);
            b = a ^ ($urandom & m);
            for (int s = 0; s < 2; s++) begin
                run_req(s[0], a, b, lat, res, bb);
                exp_lat = ref_lat(s[0], a ^ b);
                $display("rand %0d ee=%0d a=%h b=%h lat=%0d ham=%0d", t, s, a, b, lat, res);
                n_cmp++;
                if (lat !== exp_lat || res !== 6'(ref_pop(a ^ b)) || bb !== 0) begin
                    n_err++;
                    $display("FAIL rand_%0d_ee%0d got lat=%0d ham=%0d busybad=%0d exp lat=%0d ham=%0d",
                             t, s, lat, res, bb, exp_lat, ref_pop(a ^ b));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_equal();
        test_early_low();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hamming_dist_seq.md
# hamming_dist_seq

Multi-cycle Hamming-distance engine for the Mini RISC execute stage. It sits directly upstream of the writeback mux, alongside the combinational popcount unit. It takes two 32-bit register operands, forms their XOR, and counts the differing bits CHUNK bits per cycle. Under a start/busy/done handshake it returns the distance on a registered output. This trades latency for a much smaller adder tree than a single-cycle 32-bit popcount.

## Interface
- WIDTH, 32, operand width; must be a multiple of CHUNK
- CHUNK, 4, bits counted per COUNT cycle
- EARLY_EXIT, 1, 1 = finish as soon as the remaining XOR bits are all zero
- clk  input  1  rising-edge clock; single clock domain
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled on clk, accepted only in IDLE or DONE
- src1  input  WIDTH  operand A; sampled only on the accepting edge
- src2  input  WIDTH  operand B; sampled only on the accepting edge
- busy  output  1  high while in COUNT
- done  output  1  one-cycle pulse; high exactly while in DONE
- ham_out  output  $clog2(WIDTH)+1 (6)  last completed distance; held until the next completion

## Operation
- Three states: IDLE, COUNT, DONE.
  - IDLE: on start, go to COUNT.
  - COUNT: stay for N = WIDTH/CHUNK cycles, or fewer with EARLY_EXIT; then go to DONE.
  - DONE: lasts one cycle. With start asserted, go to COUNT (back-to-back); otherwise go to IDLE.
- Accepting edge:
  - diff <= src1 ^ src2
  - acc <= 0
  - idx <= 0
- Each COUNT edge:
  - acc <= acc + popcount(diff[CHUNK-1:0])
  - diff <= diff >> CHUNK
  - idx <= idx + 1
  - When idx == N-1, go to DONE and load ham_out with the final sum (acc + this chunk's count).
- EARLY_EXIT=1:
  - On a COUNT edge where diff == 0, go to DONE with ham_out <= acc and no accumulate.
  - This check takes priority over the idx test.
- Widths:
  - acc and ham_out are $clog2(WIDTH)+1 bits; the maximum value is WIDTH (32), which fits without overflow.
  - Per-chunk count is $clog2(CHUNK)+1 bits, zero-extended before the add.
  - idx is $clog2(N) bits. It wraps only through restart; it never counts past N-1.
- start while busy is ignored: no queuing, no effect on the in-flight operation.
- Operand changes after the accepting edge have no effect.
- Reset, including mid-operation:
  - state = IDLE
  - busy = 0, done = 0
  - ham_out = 0, acc = 0, diff = 0, idx = 0
  - Any in-flight result is discarded.
- rst has priority over start on the same edge.

## Timing
- Accepting edge is E0. busy is high from E0 to the exit edge; done is high for the single cycle after the exit edge.
- Full run (EARLY_EXIT=0, or with a difference in the top chunk):
  - exit at E(N), i.e. E8 for the defaults
  - done high during cycle [E8, E9)
  - latency from start sample to done is N cycles
- Early exit:
  - exit at E(k+1), where k is the number of chunks up to and including the highest chunk containing a 1
  - src1 == src2: exit at E1, done in [E1, E2), ham_out = 0
- ham_out changes only on the exit edge. It is valid whenever done is high and remains stable through IDLE and subsequent COUNT cycles.
- Back-to-back: start held high through DONE is accepted at that edge, so busy rises at the edge where done falls. Throughput is one result per N+1 cycles.
- Outputs are fully registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package ham_pkg:
  - state enum (IDLE, COUNT, DONE)
  - localparam defaults for WIDTH and CHUNK
  - helper for result width, $clog2(WIDTH)+1
- Sub-module chunk_popcount: combinational, CHUNK-bit input, count output. It is instantiated once and feeds the accumulator adder.
- Top level holds the FSM, diff shift register, idx counter, acc, and ham_out.

## Test plan
- Reset behaviour:
  - rst held for 2 cycles → busy=0, done=0, ham_out=0.
  - Then start with src1=32'hFFFF_FFFF, src2=0 and EARLY_EXIT=0 → busy for 8 cycles, done in the 9th cycle after start, ham_out=32.
- Equal operands, EARLY_EXIT=1: src1=src2=32'hDEAD_BEEF → done one cycle after the accepting edge, ham_out=0.
- Early exit on a low chunk: src1=32'h0000_000F, src2=32'h0000_0001 with EARLY_EXIT=1 → ham_out=3, done at E2 instead of E8.
- Busy and back-to-back handling:
  - src1=32'hA5A5_A5A5, src2=32'h5A5A_5A5A → ham_out=32.
  - Toggle start and the operands during busy → no effect.
  - Hold start high in DONE with new operands 32'h1 / 32'h0 → second result 1, and ham_out stays 32 until the second exit edge.
- Reset mid-COUNT: assert rst at E4 → next cycle busy=0, ham_out=0. A subsequent start behaves normally.
- Randomised: 1000 random operand pairs, each a single request → ham_out equals the reference popcount(src1^src2). Latency matches the early-exit rule for both EARLY_EXIT settings.
